// File: rtl/mult_pkg.sv
// mult_pkg
// Shared definitions for the sequential multiplier:
//   - state_t : binary-encoded controller states (S_IDLE, S_ITER, S_DONE);
//               the fourth code is unused and decodes back to S_IDLE
//   - MODE_SHIFT_ADD / MODE_REPEAT_ADD : algorithm selector values
//   - W_MIN / W_MAX : supported operand width range
package mult_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ITER = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam int MODE_SHIFT_ADD  = 0;
    localparam int MODE_REPEAT_ADD = 1;

    localparam int W_MIN = 2;
    localparam int W_MAX = 32;

endpackage

// File: rtl/mult_datapath.sv
// mult_datapath
// Operand/accumulator registers for the sequential multiplier.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset, clears every register
//   ld       : capture a (zero-extended) into A, b into B, clear P
//   step     : perform one iteration of the selected algorithm
//   ld_prod  : copy the accumulator P into the product register
//   a, b     : W-bit operands
//   eqz      : B register is zero (derived from the register, not the input)
//   product  : 2W-bit result register, held between completions
module mult_datapath
    import mult_pkg::*;
#(
    parameter int W    = 8,
    parameter int MODE = MODE_SHIFT_ADD
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld,
    input  logic           step,
    input  logic           ld_prod,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           eqz,
    output logic [2*W-1:0] product
);

    logic [2*W-1:0] a_reg;
    logic [W-1:0]   b_reg;
    logic [2*W-1:0] p_reg;
    logic [2*W-1:0] prod_reg;

    logic [2*W-1:0] a_next;
    logic [W-1:0]   b_next;
    logic [2*W-1:0] p_next;
    logic [2*W-1:0] sum;

    // Single adder shared by both algorithms; no carry out is needed since
    // the final product always fits in 2W bits.
    assign sum = p_reg + a_reg;

    generate
        if (MODE == MODE_SHIFT_ADD) begin : g_shift_add
            // Add A only when the current multiplier LSB is set, then move
            // to the next bit position. A cannot lose set bits because B is
            // exhausted after at most W-1 shifts.
            assign p_next = b_reg[0] ? sum : p_reg;
            assign a_next = {a_reg[2*W-2:0], 1'b0};
            assign b_next = {1'b0, b_reg[W-1:1]};
        end else begin : g_repeat_add
            assign p_next = sum;
            assign a_next = a_reg;
            assign b_next = b_reg - W'(1);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            p_reg    <= '0;
            prod_reg <= '0;
        end else begin
            if (ld) begin
                a_reg <= {{W{1'b0}}, a};
                b_reg <= b;
                p_reg <= '0;
            end else if (step) begin
                a_reg <= a_next;
                b_reg <= b_next;
                p_reg <= p_next;
            end
            if (ld_prod) begin
                prod_reg <= p_reg;
            end
        end
    end

    assign eqz     = (b_reg == '0);
    assign product = prod_reg;

endmodule

// File: rtl/seq_mult_unit.sv
// seq_mult_unit
// Sequential unsigned multiplier: controller FSM plus mult_datapath.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   start    : operation request, honoured only in IDLE or DONE
//   a, b     : W-bit operands, captured on the accepting edge
//   abort    : cancels an operation in progress (ITER only)
//   busy     : high while iterating
//   done     : one-cycle pulse when product has just been updated
//   product  : 2W-bit last completed result
// MODE selects shift-add (0) or repeated addition (1).
module seq_mult_unit
    import mult_pkg::*;
#(
    parameter int W    = 8,
    parameter int MODE = MODE_SHIFT_ADD
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    state_t state_reg;
    state_t state_next;

    logic ld;
    logic step;
    logic ld_prod;
    logic eqz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ld         = 1'b0;
        step       = 1'b0;
        ld_prod    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    ld         = 1'b1;
                    state_next = S_ITER;
                end
            end
            S_ITER: begin
                // abort wins over completion; start is ignored here
                if (abort) begin
                    state_next = S_IDLE;
                end else if (eqz) begin
                    ld_prod    = 1'b1;
                    state_next = S_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            S_DONE: begin
                // A start in the done cycle chains straight into the next
                // operation without passing through IDLE.
                if (start) begin
                    ld         = 1'b1;
                    state_next = S_ITER;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Status outputs are pure state decodes, so no input reaches an output
    // combinationally.
    assign busy = (state_reg == S_ITER);
    assign done = (state_reg == S_DONE);

    mult_datapath #(
        .W    (W),
        .MODE (MODE)
    ) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .ld      (ld),
        .step    (step),
        .ld_prod (ld_prod),
        .a       (a),
        .b       (b),
        .eqz     (eqz),
        .product (product)
    );

endmodule

// File: tb/tb_seq_mult_unit.sv
// tb_seq_mult_unit
// Drives two multiplier instances (W = 8): index 0 uses shift-add, index 1
// uses repeated addition. Expected products and latencies come from plain
// arithmetic on the operands.
module tb_seq_mult_unit;

    localparam int W = 8;

    logic clk;
    logic rst;
    logic [1:0]          start_v;
    logic [1:0]          abort_v;
    logic [1:0][W-1:0]   a_v;
    logic [1:0][W-1:0]   b_v;
    logic [1:0]          busy_v;
    logic [1:0]          done_v;
    logic [1:0][2*W-1:0] prod_v;

    int checks = 0;
    int errors = 0;

    seq_mult_unit #(.W(W), .MODE(0)) u_dut_shift (
        .clk     (clk),
        .rst     (rst),
        .start   (start_v[0]),
        .a       (a_v[0]),
        .b       (b_v[0]),
        .abort   (abort_v[0]),
        .busy    (busy_v[0]),
        .done    (done_v[0]),
        .product (prod_v[0])
    );

    seq_mult_unit #(.W(W), .MODE(1)) u_dut_repeat (
        .clk     (clk),
        .rst     (rst),
        .start   (start_v[1]),
        .a       (a_v[1]),
        .b       (b_v[1]),
        .abort   (abort_v[1]),
        .busy    (busy_v[1]),
        .done    (done_v[1]),
        .product (prod_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          mode;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [15:0] exp_prod;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Iterations: bit-length of b for shift-add, b itself for repeated add.
    function automatic int ref_iters(input int mode, input int bv);
        int n = 0;
        int x = bv;
        if (mode == 1) return bv;
        while (x != 0) begin
            n++;
            x = x / 2;
        end
        return n;
    endfunction

    // Edges after the accepting edge until the one that raises done.
    function automatic int ref_lat(input int mode, input int bv);
        return ref_iters(mode, bv) + 1;
    endfunction

    // Counts edges from now until done is seen; bounded.
    task automatic wait_done(input int m, output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (!done_v[m] && cyc < 2000) begin
            if (busy_v[m]) bcnt++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_op(input int m, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input string tag);
        int cyc;
        int bcnt;
        int exp_lat = ref_lat(m, int'(bv));
        longint exp_p = longint'(av) * longint'(bv);
        @(negedge clk);
        a_v[m] = av;
        b_v[m] = bv;
        start_v[m] = 1'b1;
        @(posedge clk); #1;
        start_v[m] = 1'b0;
        wait_done(m, cyc, bcnt);
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " busy cycles"}, bcnt, exp_lat);
        check({tag, " busy low at done"}, busy_v[m], 0);
        check({tag, " product"}, prod_v[m], exp_p);
        $display("op mode=%0d a=%0d b=%0d product=%0d latency=%0d", m, av, bv, prod_v[m], cyc);
        @(posedge clk); #1;
        check({tag, " done one cycle"}, done_v[m], 0);
        check({tag, " product held"}, prod_v[m], exp_p);
    endtask

    vec_t tbl[5];

    initial begin
        int cyc;
        int bcnt;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst = 1'b0;
        start_v = '0;
        abort_v = '0;
        a_v = '0;
        b_v = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            check("reset busy", busy_v[m], 0);
            check("reset done", done_v[m], 0);
            check("reset product", prod_v[m], 0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        a_v[0] = 8'd200;
        b_v[0] = 8'd150;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        check("pre-reset busy", busy_v[0], 1);
        rst = 1'b0;
        #1;
        check("mid-op reset busy", busy_v[0], 0);
        check("mid-op reset done", done_v[0], 0);
        check("mid-op reset product", prod_v[0], 0);
        $display("op mode=0 a=200 b=150 reset mid-operation");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("after reset no done", done_v[0], 0);

        // Directed vectors
        tbl[0] = '{0, 8'd13,  8'd11,  16'd143,   5};
        tbl[1] = '{0, 8'd255, 8'd0,   16'd0,     1};
        tbl[2] = '{0, 8'd255, 8'd255, 16'd65025, 9};
        tbl[3] = '{1, 8'd7,   8'd5,   16'd35,    6};
        tbl[4] = '{1, 8'd0,   8'd3,   16'd0,     4};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_v[tbl[i].mode] = tbl[i].a;
            b_v[tbl[i].mode] = tbl[i].b;
            start_v[tbl[i].mode] = 1'b1;
            @(posedge clk); #1;
            start_v[tbl[i].mode] = 1'b0;
            wait_done(tbl[i].mode, cyc, bcnt);
            check($sformatf("vec%0d latency", i), cyc, tbl[i].exp_lat);
            check($sformatf("vec%0d busy cycles", i), bcnt, tbl[i].exp_lat);
            check($sformatf("vec%0d product", i), prod_v[tbl[i].mode], tbl[i].exp_prod);
            $display("vec%0d mode=%0d a=%0d b=%0d product=%0d latency=%0d", i,
                     tbl[i].mode, tbl[i].a, tbl[i].b, prod_v[tbl[i].mode], cyc);
            @(posedge clk); #1;
        end

        // start during ITER is ignored; start in DONE chains directly
        @(negedge clk);
        a_v[0] = 8'd13;
        b_v[0] = 8'd11;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        a_v[0] = 8'd50;
        b_v[0] = 8'd60;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        wait_done(0, cyc, bcnt);
        check("ignored start latency", cyc + 2, 5);
        check("ignored start product", prod_v[0], 143);
        $display("op mode=0 a=13 b=11 with start in ITER product=%0d", prod_v[0]);
        a_v[0] = 8'd3;
        b_v[0] = 8'd4;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        check("back-to-back busy", busy_v[0], 1);
        check("back-to-back done", done_v[0], 0);
        wait_done(0, cyc, bcnt);
        check("back-to-back latency", cyc, ref_lat(0, 4));
        check("back-to-back product", prod_v[0], 12);
        $display("op mode=0 a=3 b=4 back-to-back product=%0d", prod_v[0]);
        @(posedge clk); #1;

        // Abort on the second ITER cycle
        run_op(0, 8'd13, 8'd11, "pre-abort");
        @(negedge clk);
        a_v[0] = 8'd9;
        b_v[0] = 8'd9;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        abort_v[0] = 1'b1;
        @(posedge clk); #1;
        abort_v[0] = 1'b0;
        check("abort busy", busy_v[0], 0);
        bcnt = 0;
        for (int k = 0; k < 15; k++) begin
            if (done_v[0] || busy_v[0]) bcnt++;
            @(posedge clk); #1;
        end
        check("abort no activity", bcnt, 0);
        check("abort product kept", prod_v[0], 143);
        $display("op mode=0 a=9 b=9 aborted product=%0d", prod_v[0]);

        // Randomised operations on both algorithms
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = (i % 2 == 1) ? W'($urandom_range(0, 40)) : W'($urandom_range(0, 255));
            run_op(i % 2, ra, rb, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
